// File: rtl/cam_mac_table_ctrl.sv
// cam_mac_table_ctrl: serialises MAC learn/lookup requests onto a shift-register CAM and owns the valid/port tables
module cam_mac_table_ctrl #(
    parameter  int DATA_WIDTH = 48,
    parameter  int ADDR_WIDTH = 5,
    parameter  int PORT_WIDTH = 2,
    localparam int N          = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_valid,
    output logic                  lookup_ready,
    input  logic [DATA_WIDTH-1:0] lookup_mac,
    input  logic                  learn_valid,
    output logic                  learn_ready,
    input  logic [DATA_WIDTH-1:0] learn_mac,
    input  logic [PORT_WIDTH-1:0] learn_port,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [PORT_WIDTH-1:0] resp_port,
    output logic [ADDR_WIDTH-1:0] resp_index,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic [N-1:0]          cam_match_many
);
    typedef enum logic [2:0] {IDLE, LK_WAIT, LK_RESP, LN_WAIT, LN_WRITE, LN_SKIP, LN_BUSY} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mac_q, mac_d;
    logic [PORT_WIDTH-1:0] lport_q, lport_d;
    logic [N-1:0]          valid_q, valid_d;
    logic [PORT_WIDTH-1:0] port_q [N];
    logic [PORT_WIDTH-1:0] port_d [N];
    logic [ADDR_WIDTH-1:0] rr_q, rr_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  resp_hit_q, resp_hit_d;
    logic [PORT_WIDTH-1:0] resp_port_q, resp_port_d;
    logic [ADDR_WIDTH-1:0] resp_index_q, resp_index_d;
    logic [N-1:0]          hits;
    logic [ADDR_WIDTH-1:0] hit_idx, free_idx;
    logic                  hit_any, free_any;
    logic                  idle_rdy, learn_rdy, wr_en;

    assign hits     = cam_match_many & valid_q;
    assign hit_any  = |hits;
    assign free_any = ~&valid_q;

    // Lowest-index qualified hit and lowest-index free entry
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hits[i]) hit_idx = ADDR_WIDTH'(i);
            if (!valid_q[i]) free_idx = ADDR_WIDTH'(i);
        end
    end

    // Next-state, table updates and handshake strobes
    always_comb begin
        state_d      = state_q;
        mac_d        = mac_q;
        lport_d      = lport_q;
        valid_d      = valid_q;
        port_d       = port_q;
        rr_d         = rr_q;
        target_d     = target_q;
        resp_hit_d   = resp_hit_q;
        resp_port_d  = resp_port_q;
        resp_index_d = resp_index_q;
        idle_rdy     = 1'b0;
        learn_rdy    = 1'b0;
        wr_en        = 1'b0;
        case (state_q)
            IDLE: begin
                idle_rdy  = 1'b1;
                learn_rdy = !lookup_valid && !cam_write_busy;
                if (lookup_valid) begin
                    mac_d   = lookup_mac;
                    state_d = LK_WAIT;
                end else if (learn_valid && learn_rdy) begin
                    mac_d   = learn_mac;
                    lport_d = learn_port;
                    state_d = LN_WAIT;
                end
            end
            LK_WAIT: begin
                resp_hit_d   = hit_any;
                resp_port_d  = hit_any ? port_q[hit_idx] : '0;
                resp_index_d = hit_any ? hit_idx : '0;
                state_d      = LK_RESP;
            end
            LK_RESP: state_d = IDLE;
            LN_WAIT: begin
                if (hit_any) begin
                    port_d[hit_idx] = lport_q;
                    state_d         = IDLE;
                end else begin
                    target_d = free_any ? free_idx : rr_q;
                    rr_d     = free_any ? rr_q : rr_q + 1'b1;
                    state_d  = LN_WRITE;
                end
            end
            LN_WRITE: begin
                if (!cam_write_busy) begin
                    wr_en            = 1'b1;
                    valid_d[target_q] = 1'b1;
                    port_d[target_q]  = lport_q;
                    state_d          = LN_SKIP;
                end
            end
            LN_SKIP: state_d = LN_BUSY;
            LN_BUSY: state_d = cam_write_busy ? LN_BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and table registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mac_q        <= '0;
            lport_q      <= '0;
            valid_q      <= '0;
            port_q       <= '{default: '0};
            rr_q         <= '0;
            target_q     <= '0;
            resp_hit_q   <= 1'b0;
            resp_port_q  <= '0;
            resp_index_q <= '0;
        end else begin
            state_q      <= state_d;
            mac_q        <= mac_d;
            lport_q      <= lport_d;
            valid_q      <= valid_d;
            port_q       <= port_d;
            rr_q         <= rr_d;
            target_q     <= target_d;
            resp_hit_q   <= resp_hit_d;
            resp_port_q  <= resp_port_d;
            resp_index_q <= resp_index_d;
        end
    end

    assign lookup_ready     = rst_n && idle_rdy;
    assign learn_ready      = rst_n && learn_rdy;
    assign resp_valid       = state_q == LK_RESP;
    assign resp_hit         = resp_hit_q;
    assign resp_port        = resp_port_q;
    assign resp_index       = resp_index_q;
    assign cam_write_enable = wr_en;
    assign cam_write_addr   = wr_en ? target_q : '0;
    assign cam_write_data   = wr_en ? mac_q : '0;
    assign cam_write_delete = 1'b0;
    assign cam_compare_data = state_q == IDLE ? (lookup_valid ? lookup_mac : learn_mac) : mac_q;
endmodule

// File: tb/tb_cam_mac_table_ctrl.sv
// tb_cam_mac_table_ctrl: randomized self-checking bench with a behavioural CAM and a table reference model
module tb_cam_mac_table_ctrl;
    localparam int DW = 48, AW = 5, PW = 2, N = 32, INIT = 20;

    logic          clk = 0, rst_n = 0;
    logic          lookup_valid = 0, lookup_ready, learn_valid = 0, learn_ready;
    logic [DW-1:0] lookup_mac = '0, learn_mac = '0;
    logic [PW-1:0] learn_port = '0;
    logic          resp_valid, resp_hit;
    logic [PW-1:0] resp_port;
    logic [AW-1:0] resp_index, cam_write_addr;
    logic [DW-1:0] cam_write_data, cam_compare_data;
    logic          cam_write_delete, cam_write_enable, cam_write_busy;
    logic [N-1:0]  cam_match_many;

    int n_tests = 0, n_fail = 0;

    cam_mac_table_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PORT_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_mac(lookup_mac),
        .learn_valid(learn_valid), .learn_ready(learn_ready), .learn_mac(learn_mac), .learn_port(learn_port),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_port(resp_port), .resp_index(resp_index),
        .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data), .cam_write_delete(cam_write_delete),
        .cam_write_enable(cam_write_enable), .cam_write_busy(cam_write_busy),
        .cam_compare_data(cam_compare_data), .cam_match_many(cam_match_many)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: init busy after reset, registered match, busy raised one cycle after a write
    logic [DW-1:0] cam_key [N];
    logic [N-1:0]  cam_v;
    int            init_cnt, wr_cnt;
    logic          wr_start;
    logic [AW-1:0] wr_addr_m;
    logic [DW-1:0] wr_data_m;
    always @(posedge clk) begin
        if (!rst_n) begin
            cam_v <= '0;
            cam_write_busy <= 1;
            init_cnt <= INIT;
            wr_start <= 0;
            wr_cnt <= 0;
            cam_match_many <= '0;
        end else begin
            for (int i = 0; i < N; i++) cam_match_many[i] <= cam_v[i] && cam_key[i] == cam_compare_data;
            if (init_cnt > 0) begin
                init_cnt <= init_cnt - 1;
                if (init_cnt == 1) cam_write_busy <= 0;
            end
            if (cam_write_enable) begin
                cam_v[cam_write_addr] <= 0;
                wr_addr_m <= cam_write_addr;
                wr_data_m <= cam_write_data;
                wr_start <= 1;
            end
            if (wr_start) begin
                wr_start <= 0;
                cam_write_busy <= 1;
                wr_cnt <= 3;
            end
            if (wr_cnt > 0) begin
                wr_cnt <= wr_cnt - 1;
                if (wr_cnt == 1) begin
                    cam_write_busy <= 0;
                    cam_key[wr_addr_m] <= wr_data_m;
                    cam_v[wr_addr_m] <= 1;
                end
            end
        end
    end

    // Reference MAC table
    logic [DW-1:0] rm_mac [N];
    logic [PW-1:0] rm_port [N];
    bit            rm_v [N];
    int            rm_rr;

    function automatic void ref_clear();
        for (int i = 0; i < N; i++) rm_v[i] = 0;
        rm_rr = 0;
    endfunction

    function automatic void ref_lookup(input logic [DW-1:0] mac, output logic hit, output logic [PW-1:0] port,
                                       output logic [AW-1:0] idx);
        hit = 0; port = '0; idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rm_v[i] && rm_mac[i] == mac) begin hit = 1; port = rm_port[i]; idx = AW'(i); end
    endfunction

    function automatic void ref_learn(input logic [DW-1:0] mac, input logic [PW-1:0] port, output bit wr, output int addr);
        int h = -1, f = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (rm_v[i] && rm_mac[i] == mac) h = i;
            if (!rm_v[i]) f = i;
        end
        if (h >= 0) begin
            rm_port[h] = port; wr = 0; addr = h;
        end else begin
            wr = 1;
            addr = f >= 0 ? f : rm_rr;
            if (f < 0) rm_rr = (rm_rr + 1) % N;
            rm_v[addr] = 1; rm_mac[addr] = mac; rm_port[addr] = port;
        end
    endfunction

    task automatic drive_lookup(input logic [DW-1:0] mac, output logic hit, output logic [PW-1:0] port,
                                output logic [AW-1:0] idx, output int lat);
        int w = 0;
        @(negedge clk); lookup_valid = 1; lookup_mac = mac; #1;
        while (!lookup_ready && w < 100) begin @(negedge clk); #1; w++; end
        @(posedge clk); #1; lookup_valid = 0;
        lat = -1; hit = 'x; port = 'x; idx = 'x;
        for (int c = 1; c <= 6 && lat < 0; c++) begin
            @(negedge clk);
            if (resp_valid) begin lat = c; hit = resp_hit; port = resp_port; idx = resp_index; end
        end
    endtask

    task automatic drive_learn(input logic [DW-1:0] mac, input logic [PW-1:0] port, output int we_cnt,
                               output int we_addr, output bit done);
        int w = 0;
        @(negedge clk); learn_valid = 1; learn_mac = mac; learn_port = port; #1;
        while (!learn_ready && w < 100) begin @(negedge clk); #1; w++; end
        @(posedge clk); #1; learn_valid = 0;
        we_cnt = 0; we_addr = -1; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (cam_write_enable) begin we_cnt++; we_addr = cam_write_addr; end
            if (lookup_ready) done = 1;
        end
    endtask

    task automatic reset_and_init();
        int w = 0;
        @(negedge clk); rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1; ref_clear();
        while (cam_write_busy && w < 200) begin @(negedge clk); w++; end
    endtask

    task automatic check_lookup(input string name, input logic [DW-1:0] mac);
        logic hit, ehit; logic [PW-1:0] port, eport; logic [AW-1:0] idx, eidx; int lat;
        drive_lookup(mac, hit, port, idx, lat);
        ref_lookup(mac, ehit, eport, eidx);
        n_tests++;
        if (lat !== 2 || hit !== ehit || port !== eport || idx !== eidx) begin
            n_fail++;
            $display("FAIL %s mac=%0h: got lat=%0d hit=%0b port=%0d idx=%0d want lat=2 hit=%0b port=%0d idx=%0d",
                     name, mac, lat, hit, port, idx, ehit, eport, eidx);
        end
    endtask

    task automatic check_learn(input string name, input logic [DW-1:0] mac, input logic [PW-1:0] port);
        int we_cnt, we_addr, eaddr; bit done, ewr;
        drive_learn(mac, port, we_cnt, we_addr, done);
        ref_learn(mac, port, ewr, eaddr);
        n_tests++;
        if (!done || we_cnt !== int'(ewr) || (ewr && we_addr !== eaddr)) begin
            n_fail++;
            $display("FAIL %s mac=%0h: got done=%0b writes=%0d addr=%0d want done=1 writes=%0d addr=%0d",
                     name, mac, done, we_cnt, we_addr, ewr, eaddr);
        end
    endtask

    task automatic test_reset();
        logic hit; logic [PW-1:0] port; logic [AW-1:0] idx; int lat, w = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({lookup_ready, learn_ready, resp_valid, resp_hit, resp_port, resp_index, cam_write_enable,
             cam_write_delete, cam_write_addr, cam_write_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%0b%0b resp=%0b%0b%0d%0d we=%0b del=%0b addr=%0d data=%0h want all 0",
                     lookup_ready, learn_ready, resp_valid, resp_hit, resp_port, resp_index, cam_write_enable,
                     cam_write_delete, cam_write_addr, cam_write_data);
        end
        rst_n = 1; ref_clear(); #1;
        n_tests++;
        if (lookup_ready !== 1) begin n_fail++; $display("FAIL init_lookup_ready: got %0b want 1", lookup_ready); end
        drive_lookup(48'h0A0B0C0D0E0F, hit, port, idx, lat);
        n_tests++;
        if (lat !== 2 || hit !== 0 || port !== 0 || idx !== 0) begin
            n_fail++;
            $display("FAIL init_lookup_miss: got lat=%0d hit=%0b port=%0d idx=%0d want 2 0 0 0", lat, hit, port, idx);
        end
        @(negedge clk); learn_valid = 1; learn_mac = 48'h111111111111; learn_port = 1; #1;
        while (w < 100) begin
            if (!cam_write_busy) break;
            n_tests++;
            if (learn_ready !== 0) begin n_fail++; $display("FAIL learn_ready_during_init: got %0b want 0", learn_ready); end
            @(negedge clk); #1; w++;
        end
        n_tests++;
        if (learn_ready !== 1 || cam_write_busy !== 0) begin
            n_fail++;
            $display("FAIL learn_ready_after_init: got ready=%0b busy=%0b want 1 0", learn_ready, cam_write_busy);
        end
        learn_valid = 0;
    endtask

    task automatic test_learn_lookup();
        check_learn("learn_first", 48'h001122334455, 2);
        check_lookup("lookup_learned", 48'h001122334455);
        n_tests++;
        if (rm_port[0] !== 2 || !rm_v[0] || rm_mac[0] !== 48'h001122334455) begin
            n_fail++; $display("FAIL model_entry0: got port=%0d want 2", rm_port[0]);
        end
    endtask

    task automatic test_miss();
        check_lookup("lookup_unknown", 48'h0000DEADBEEF);
    endtask

    task automatic test_relearn();
        check_learn("relearn_no_write", 48'h001122334455, 1);
        check_lookup("lookup_relearned", 48'h001122334455);
    endtask

    task automatic test_fill_evict();
        reset_and_init();
        for (int i = 0; i < N + 2; i++) check_learn("fill_learn", {16'hA5A5, 32'(i)}, PW'(i));
        for (int i = 0; i < N + 2; i++) check_lookup("fill_lookup", {16'hA5A5, 32'(i)});
        n_tests++;
        if (rm_mac[0] !== {16'hA5A5, 32'(N)} || rm_mac[1] !== {16'hA5A5, 32'(N + 1)}) begin
            n_fail++; $display("FAIL evict_targets: got %0h %0h want rr overwrite of 0 and 1", rm_mac[0], rm_mac[1]);
        end
    endtask

    task automatic test_back_to_back();
        int resp_c = -1, acc_c = -1, we_c = -1, eaddr, we_addr = -1; bit ewr;
        logic ehit; logic [PW-1:0] eport; logic [AW-1:0] eidx;
        ref_lookup({16'hA5A5, 32'd5}, ehit, eport, eidx);
        @(negedge clk);
        lookup_valid = 1; lookup_mac = {16'hA5A5, 32'd5};
        learn_valid = 1; learn_mac = 48'h0C0FFEE00001; learn_port = 3; #1;
        n_tests++;
        if (lookup_ready !== 1 || learn_ready !== 0) begin
            n_fail++; $display("FAIL b2b_priority: got lk=%0b ln=%0b want 1 0", lookup_ready, learn_ready);
        end
        @(posedge clk); #1; lookup_valid = 0;
        for (int c = 1; c <= 10 && acc_c < 0; c++) begin
            @(negedge clk); #1;
            if (resp_valid && resp_c < 0) begin
                resp_c = c;
                n_tests++;
                if (resp_hit !== ehit || resp_port !== eport || resp_index !== eidx) begin
                    n_fail++;
                    $display("FAIL b2b_resp: got %0b %0d %0d want %0b %0d %0d", resp_hit, resp_port, resp_index, ehit, eport, eidx);
                end
            end
            if (learn_ready) acc_c = c;
        end
        n_tests++;
        if (resp_c !== 2 || acc_c !== 3) begin
            n_fail++; $display("FAIL b2b_order: got resp@%0d learn@%0d want resp@2 learn@3", resp_c, acc_c);
        end
        @(posedge clk); #1; learn_valid = 0;
        ref_learn(48'h0C0FFEE00001, 3, ewr, eaddr);
        for (int c = 0; c < 20 && we_c < 0; c++) begin
            @(negedge clk);
            if (cam_write_enable) begin we_c = c; we_addr = cam_write_addr; end
        end
        n_tests++;
        if (we_c < 0 || we_addr !== eaddr) begin
            n_fail++; $display("FAIL b2b_write: got seen=%0b addr=%0d want seen=1 addr=%0d", we_c >= 0, we_addr, eaddr);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (lookup_ready !== 0 || cam_write_busy !== 1) begin
            n_fail++; $display("FAIL ln_busy_state: got rdy=%0b busy=%0b want 0 1", lookup_ready, cam_write_busy);
        end
        rst_n = 0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (resp_valid !== 0 || lookup_ready !== 0 || cam_write_enable !== 0) begin
                n_fail++; $display("FAIL abort_reset: got resp=%0b rdy=%0b we=%0b want 0 0 0", resp_valid, lookup_ready, cam_write_enable);
            end
        end
        rst_n = 1; ref_clear(); #1;
        n_tests++;
        if (lookup_ready !== 1 || learn_ready !== 0) begin
            n_fail++; $display("FAIL abort_idle: got lk=%0b ln=%0b want 1 0", lookup_ready, learn_ready);
        end
        for (int w = 0; w < 200 && cam_write_busy; w++) @(negedge clk);
        check_lookup("lookup_after_abort", {16'hA5A5, 32'd5});
    endtask

    task automatic test_random();
        logic [DW-1:0] pool [40];
        for (int k = 0; k < 40; k++) pool[k] = {16'(k + 16'h1000), 32'($urandom)};
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 2))
                0: check_learn("rand_learn", pool[$urandom_range(0, 39)], PW'($urandom));
                1: check_lookup("rand_lookup", pool[$urandom_range(0, 39)]);
                default: check_lookup("rand_unknown", {16'hFFFF, 32'($urandom)});
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_learn_lookup();
        test_miss();
        test_relearn();
        test_fill_evict();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
